// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, counter state encoding and nibble validity check
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit of a borrow-chained decrementer
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] next_digit,
  output logic             borrow_out
);
  assign borrow_out = borrow_in && digit == '0;
  assign next_digit = !borrow_in ? digit : digit == '0 ? BCD_MAX : digit - 4'd1;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD countdown timer with terminal-count pulse
// Optional BCD_DOWN_AUTO_RELOAD_EN: restart from the last preset after reaching zero.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    enable,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    zero,
  output logic                    tc_pulse,
  output logic                    busy,
  output logic                    load_err
);
  localparam int W = BCD_W * DIGITS;
  state_t state, state_d;
  logic [W-1:0] count_d, dec;
  logic [DIGITS:0] borrow;
  logic [DIGITS-1:0] nib_ok;
  logic ld_ok, tc_d, err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
  logic [W-1:0] reload_reg, reload_d;
`endif
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_dec u_dec (
      .digit     (count[i*BCD_W +: BCD_W]),
      .borrow_in (borrow[i]),
      .next_digit(dec[i*BCD_W +: BCD_W]),
      .borrow_out(borrow[i+1])
    );
    assign nib_ok[i] = bcd_valid(load_value[i*BCD_W +: BCD_W]);
  end
  // A borrow rippling out of the top digit means every digit is zero.
  assign zero  = borrow[DIGITS];
  assign ld_ok = &nib_ok;
  assign busy  = state == RUN;
  always_comb begin
    state_d = state;
    count_d = count;
    tc_d    = 1'b0;
    err_d   = 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    reload_d = reload_reg;
`endif
    if (load) begin
      if (ld_ok) begin
        count_d = load_value;
        state_d = load_value == '0 ? DONE : RUN;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        reload_d = load_value;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (state == RUN && enable) begin
      tc_d = count == W'(1);
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      count_d = zero ? reload_reg : dec;
`else
      count_d = dec;
      state_d = tc_d ? DONE : RUN;
`endif
    end
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      count    <= '0;
      tc_pulse <= 1'b0;
      load_err <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      state    <= state_d;
      count    <= count_d;
      tc_pulse <= tc_d;
      load_err <= err_d;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_reg <= reload_d;
`endif
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed plus random stimulus against an integer countdown model
module tb_bcd_down_counter;
  localparam int D = 4;
  localparam int W = 4 * D;
  logic clock = 1'b0, clear_n = 1'b0, load = 1'b0, enable = 1'b0;
  logic [W-1:0] load_value = '0, count;
  logic zero, tc_pulse, busy, load_err;
  int n_chk = 0, n_err = 0;
  int m_val = 0, m_rel = 0;
  bit m_run = 0, m_tc = 0, m_err = 0;

  bcd_down_counter #(.DIGITS(D)) dut (
    .clock(clock), .clear_n(clear_n), .load(load), .load_value(load_value),
    .enable(enable), .count(count), .zero(zero), .tc_pulse(tc_pulse),
    .busy(busy), .load_err(load_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(to_bcd(m_val)));
    check({tag, ".zero"}, 32'(zero), 32'(m_val == 0));
    check({tag, ".tc"}, 32'(tc_pulse), 32'(m_tc));
    check({tag, ".busy"}, 32'(busy), 32'(m_run));
    check({tag, ".err"}, 32'(load_err), 32'(m_err));
  endtask

  task automatic step(input string tag, input logic ld, input logic [W-1:0] lv, input logic en);
    load = ld;
    load_value = lv;
    enable = en;
    @(posedge clock);
    #1;
    m_tc = 0;
    m_err = 0;
    if (ld) begin
      if (bcd_ok(lv)) begin
        m_val = from_bcd(lv);
        m_rel = m_val;
        m_run = m_val != 0;
      end else m_err = 1;
    end else if (m_run && en) begin
      if (m_val == 0) m_val = m_rel;
      else begin
        m_val--;
        if (m_val == 0) begin
          m_tc = 1;
`ifndef BCD_DOWN_AUTO_RELOAD_EN
          m_run = 0;
`endif
        end
      end
    end
    check_all(tag);
  endtask

  task automatic reset_check(input string tag);
    check({tag, ".count"}, 32'(count), 32'h0);
    check({tag, ".zero"}, 32'(zero), 32'h1);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".tc"}, 32'(tc_pulse), 32'h0);
    check({tag, ".err"}, 32'(load_err), 32'h0);
    m_val = 0; m_rel = 0; m_run = 0; m_tc = 0; m_err = 0;
  endtask

  initial begin
    logic [W-1:0] lv;
    int r;
    #3;
    reset_check("rst0");
    @(negedge clock);
    clear_n = 1'b1;
    step("idle_en", 0, '0, 1);
    step("ld12", 1, 16'h0012, 0);
    repeat (12) step("cnt", 0, '0, 1);
    check("tc_at_zero", 32'(tc_pulse), 32'h1);
    repeat (3) step("hold0", 0, '0, 1);
    step("ld1000", 1, 16'h1000, 0);
    step("b999", 0, '0, 1);
    check("b999_val", 32'(count), 32'h0999);
    step("ld0100", 1, 16'h0100, 0);
    step("b099", 0, '0, 1);
    check("b099_val", 32'(count), 32'h0099);
    step("ld50", 1, 16'h0050, 0);
    step("badld", 1, 16'h00A3, 0);
    check("bad_keep", 32'(count), 32'h0050);
    repeat (5) step("gate", 0, '0, 0);
    step("ld1", 1, 16'h0001, 0);
    step("prio", 1, 16'h0007, 1);
    check("prio_val", 32'(count), 32'h0007);
    step("ld0", 1, 16'h0000, 1);
    step("ld3", 1, 16'h0003, 0);
    repeat (9) step("auto", 0, '0, 1);
    step("ld2", 1, 16'h0002, 0);
    step("pre_tc", 0, '0, 1);
    step("tc_rst", 0, '0, 1);
    #2;
    clear_n = 1'b0;
    #1;
    reset_check("rst_mid");
    @(negedge clock);
    clear_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) lv = to_bcd($urandom_range(0, 25));
      else if (r < 10) lv = to_bcd($urandom_range(0, 9999));
      else if (r < 12) begin
        lv = W'($urandom);
        lv[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      end else lv = W'($urandom);
      step("rnd", r < 12, lv, $urandom_range(0, 3) != 0);
      if (k == 1500) begin
        #2;
        clear_n = 1'b0;
        #1;
        reset_check("rst_rnd");
        @(negedge clock);
        clear_n = 1'b1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
